// File: rtl/keccak_perm_arbiter.sv
// Round-robin share of one KeccakF1600 engine between absorb (0) and pad/final (1); req->perm_go 1 cycle, perm_done->ack 1 cycle.
// Requests are level-held until ack (no other backpressure); optional watchdog abort under KECCAK_ARB_TIMEOUT_EN.
module keccak_perm_arbiter #(
    parameter int W       = 1600,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             kill,
    input  logic             req0,
    input  logic [W-1:0]     state_in0,
    input  logic             req1,
    input  logic [W-1:0]     state_in1,
    output logic             ack0,
    output logic             ack1,
    output logic [W-1:0]     result_state,
    output logic             busy,
    output logic             perm_go,
    output logic [W-1:0]     perm_state_in,
    input  logic             perm_done,
    input  logic [W-1:0]     perm_state_out,
    output logic [CNT_W-1:0] perm_count,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_WAIT    = 3'd2,
        S_DELIVER = 3'd3,
        S_ABORT   = 3'd4
    } state_t;

    state_t state, state_nxt;
    logic   grant, last_grant;
    logic   win, launch, finish, tmo_hit;

`ifdef KECCAK_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
    logic          timeout_flag;

    assign tmo_hit     = (state == S_WAIT) && !perm_done && (wait_cnt == TW'(TIMEOUT - 1));
    assign timeout_err = timeout_flag;

    // The counter sits at zero outside WAIT, so it is already clear on entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
            if (tmo_hit && !kill)
                timeout_flag <= 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        finish    = 1'b0;
        // Single requester wins outright; on a tie the one not served last wins.
        if (req0 && !req1)
            win = 1'b0;
        else if (req1 && !req0)
            win = 1'b1;
        else
            win = ~last_grant;

        if (kill) begin
            state_nxt = S_ABORT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        state_nxt = S_LAUNCH;
                        launch    = 1'b1;
                    end
                end
                S_LAUNCH:  state_nxt = S_WAIT;
                S_WAIT: begin
                    if (perm_done) begin
                        state_nxt = S_DELIVER;
                        finish    = 1'b1;
                    end else if (tmo_hit) begin
                        state_nxt = S_ABORT;
                    end
                end
                S_DELIVER: state_nxt = S_IDLE;
                S_ABORT:   state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            perm_go       <= 1'b0;
            ack0          <= 1'b0;
            ack1          <= 1'b0;
            grant         <= 1'b0;
            last_grant    <= 1'b1;
            perm_state_in <= '0;
            result_state  <= '0;
            perm_count    <= '0;
        end else begin
            state   <= state_nxt;
            busy    <= (state_nxt != S_IDLE);
            perm_go <= launch;
            ack0    <= finish && !grant;
            ack1    <= finish && grant;
            if (launch) begin
                perm_state_in <= win ? state_in1 : state_in0;
                grant         <= win;
            end
            if (finish) begin
                result_state <= perm_state_out;
                perm_count   <= perm_count + 1'b1;
                last_grant   <= grant;
            end
        end
    end

endmodule
